multi_button_debouncer: RTL

- Parametrised successor to the single-button Debouncer plus the Counter's two-second hold logic, merged into one block.
- Debounces N_BUTTONS independent active-low push buttons on the 2 kHz game clock.
- Per button it produces: a debounced level, press/release pulses, short-press and long-press classification, and an optional auto-repeat.
- Sits between the board push-buttons and the BlackJack control FSM (hit/stand/bet/reset).

---
 rtl/multi_button_debouncer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/multi_button_debouncer.sv
// N-channel active-low push-button debouncer: debounced level, press/release pulses,
// short/long press classification, and auto-repeat when AUTOREPEAT_EN is defined.
module multi_button_debouncer #(
  parameter int N_BUTTONS     = 4,
  parameter int DEB_CYCLES    = 20,
  parameter int HOLD_CYCLES   = 4096,
  parameter int REPEAT_CYCLES = 500
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic [N_BUTTONS-1:0] i_Button,
  output logic [N_BUTTONS-1:0] o_ButtonDeb,
  output logic [N_BUTTONS-1:0] o_ButtonDown,
  output logic [N_BUTTONS-1:0] o_ButtonUp,
  output logic [N_BUTTONS-1:0] o_Short,
  output logic [N_BUTTONS-1:0] o_Long,
  output logic [N_BUTTONS-1:0] o_Held,
  output logic [N_BUTTONS-1:0] o_Repeat,
  output logic                 o_AnyDown
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
`ifdef AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} btn_state_e;

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
      logic              sync1_q, sync1_d, sync2_q, sync2_d;
      logic              deb_q, deb_d;
      logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      btn_state_e        state_q, state_d;
      logic              down_q, down_d, up_q, up_d;
      logic              short_q, short_d, long_q, long_d;
      logic              press_w, rel_w;

      always_comb begin
        sync1_d   = i_Button[gi];
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
        if (sync2_q == deb_q) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_d     = sync2_q;
          deb_cnt_d = '0;
        end
        press_w = deb_q & ~deb_d;
        rel_w   = ~deb_q & deb_d;

        // Counts cycles spent pressed, starting at 0 in the press-pulse cycle.
        hold_cnt_d = hold_cnt_q;
        if (deb_q || deb_d) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end

        state_d = state_q;
        long_d  = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (press_w) state_d = ST_PRESSED;
          end
          ST_PRESSED: begin
            // A release on the threshold edge takes priority over the long press.
            if (rel_w) begin
              state_d = ST_IDLE;
            end else if (hold_cnt_d == HOLD_MAX) begin
              state_d = ST_HELD;
              long_d  = 1'b1;
            end
          end
          ST_HELD: begin
            if (rel_w) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase

        down_d  = press_w;
        up_d    = rel_w;
        short_d = rel_w && (state_q != ST_HELD);
      end

      always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
          sync1_q    <= 1'b1;
          sync2_q    <= 1'b1;
          deb_q      <= 1'b1;
          deb_cnt_q  <= '0;
          hold_cnt_q <= '0;
          state_q    <= ST_IDLE;
          down_q     <= 1'b0;
          up_q       <= 1'b0;
          short_q    <= 1'b0;
          long_q     <= 1'b0;
        end else begin
          sync1_q    <= sync1_d;
          sync2_q    <= sync2_d;
          deb_q      <= deb_d;
          deb_cnt_q  <= deb_cnt_d;
          hold_cnt_q <= hold_cnt_d;
          state_q    <= state_d;
          down_q     <= down_d;
          up_q       <= up_d;
          short_q    <= short_d;
          long_q     <= long_d;
        end
      end

      assign o_ButtonDeb[gi]  = deb_q;
      assign o_ButtonDown[gi] = down_q;
      assign o_ButtonUp[gi]   = up_q;
      assign o_Short[gi]      = short_q;
      assign o_Long[gi]       = long_q;
      assign o_Held[gi]       = (state_q == ST_HELD);

`ifdef AUTOREPEAT_EN
      logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
      logic             rep_q, rep_d;

      // Counter phase is zero in the o_Long cycle, so the first pulse lands REPEAT_CYCLES later.
      always_comb begin
        rep_cnt_d = '0;
        rep_d     = 1'b0;
        if (state_q == ST_HELD && !rel_w) begin
          if (rep_cnt_q == REP_LAST) begin
            rep_d = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
      end

      always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
          rep_cnt_q <= '0;
          rep_q     <= 1'b0;
        end else begin
          rep_cnt_q <= rep_cnt_d;
          rep_q     <= rep_d;
        end
      end

      assign o_Repeat[gi] = rep_q;
`else
      assign o_Repeat[gi] = 1'b0 & (REPEAT_CYCLES > 0);
`endif
    end
  endgenerate

  assign o_AnyDown = |o_ButtonDown;

endmodule
